// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO multiply/divide unit with a restoring divider; HILO_FWD_EN bypasses HI/LO writes to the outputs
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;
  state_t state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic qs_q, qs_d, rs_q, rs_d, done_q, done_d;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH:0] sh, diff;
  logic acc, is_div, sgn;
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign sh = {rem_q, quo_q[WIDTH-1]};
  assign diff = sh - {1'b0, dvs_q};
  assign acc = start & (state_q == IDLE) & ~cancel;
  assign is_div = (op == OP_DIV) | (op == OP_DIVU);
  assign sgn = op == OP_DIV;
  assign busy = state_q != IDLE;
  assign stall = busy | (start & (state_q == IDLE) & is_div);
  assign done = done_q;
`ifdef HILO_FWD_EN
  assign hi_o = rst ? '0 : hi_d;
  assign lo_o = rst ? '0 : lo_d;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif
  // next-state: issue in IDLE, one restoring step per RUN cycle, sign fix and HI/LO write in FIX
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    lo_d = lo_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    qs_d = qs_q;
    rs_d = rs_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (acc && (op == OP_MULT || op == OP_MULTU)) begin
        {hi_d, lo_d} = op == OP_MULT ? prod_s : prod_u;
        done_d = 1'b1;
      end else if (acc && op == OP_MTHI) begin
        hi_d = a;
        done_d = 1'b1;
      end else if (acc && op == OP_MTLO) begin
        lo_d = a;
        done_d = 1'b1;
      end else if (acc && is_div) begin
        state_d = RUN;
        rem_d = '0;
        quo_d = sgn & a[WIDTH-1] ? -a : a;
        dvs_d = sgn & b[WIDTH-1] ? -b : b;
        qs_d = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        rs_d = sgn & a[WIDTH-1];
        cnt_d = CNT_W'(WIDTH);
      end
    end else if (cancel) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      rem_d = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      cnt_d = cnt_q - CNT_W'(1);
      state_d = cnt_q == CNT_W'(1) ? FIX : RUN;
    end else begin
      lo_d = qs_q ? -quo_q : quo_q;
      hi_d = rs_q ? -rem_q : rem_q;
      done_d = 1'b1;
      state_d = IDLE;
    end
  end
  // state and datapath registers, reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q <= '0;
      lo_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      qs_q <= 1'b0;
      rs_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      qs_q <= qs_d;
      rs_q <= rs_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: scoreboard bench for hilo_muldiv (default 32-bit build, optional HILO_FWD_EN)
module tb_hilo_muldiv;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cancel = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic busy, stall, done;
  logic [31:0] hi_o, lo_o;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] sb[$];
  logic skip;
  int nchk = 0, nerr = 0, bcnt = 0, dcnt = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .stall(stall), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = {m_hi, m_lo};
    case (o)
      3'd1: res = 64'(sx * sy);
      3'd2: res = {32'd0, x} * {32'd0, y};
      3'd3: if (y == 0) res = {x, x[31] ? 32'd1 : 32'hFFFFFFFF};
            else begin q = sx / sy; r = sx % sy; res = {r[31:0], q[31:0]}; end
      3'd4: res = y == 0 ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      3'd5: res = {x, m_lo};
      3'd6: res = {m_hi, x};
      default: ;
    endcase
    return res;
  endfunction

`ifdef HILO_FWD_EN
  assign skip = start & ~busy & ~cancel & (op == 3'd1 || op == 3'd2 || op == 3'd5 || op == 3'd6);
`else
  assign skip = 1'b0;
`endif

  always @(negedge clk) begin
    if (busy) bcnt++;
    if (done) begin
      dcnt++;
      if (sb.size() == 0) check("done_unexpected", 64'd1, 64'd0);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        if (!skip) check("hilo", {hi_o, lo_o}, e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // called just after an edge; leaves start asserted for exactly one edge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit acc);
    logic [63:0] r;
    start = 1'b1; op = o; a = x; b = y;
    if (acc && o >= 3'd1 && o <= 3'd6) begin
      r = model(o, x, y);
      sb.push_back(r);
      if (o != 3'd3 && o != 3'd4) {m_hi, m_lo} = r;
    end
    #1;
    if (acc) check("stall_issue", {63'd0, stall}, {63'd0, o == 3'd3 || o == 3'd4});
`ifdef HILO_FWD_EN
    if (acc && o == 3'd5) check("fwd_hi", {32'd0, hi_o}, {32'd0, x});
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!done) check("timeout", 64'd0, 64'd1);
    else {m_hi, m_lo} = {hi_o, lo_o};
  endtask

  initial begin
    int b0, d0;
    logic [2:0] ro;
    logic [31:0] ra, rb;
    cyc(2);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_flags", {61'd0, busy, done, stall}, 64'd0);
    rst = 1'b0;
    cyc(1);
    issue(3'd1, 32'hFFFFFFFD, 32'd5, 1);
    check("mult", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF1);
    check("mult_flags", {62'd0, done, busy}, 64'd2);
    issue(3'd2, 32'hFFFFFFFD, 32'd5, 1);
    check("multu", {hi_o, lo_o}, 64'h00000004_FFFFFFF1);
    cyc(1);
    b0 = bcnt; d0 = dcnt;
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 1);
    wait_done();
    check("div", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
    check("div_stall_done", {63'd0, stall}, 64'd0);
    cyc(2);
    check("div_busy_cycles", 64'(bcnt - b0), 64'd33);
    check("div_done_pulses", 64'(dcnt - d0), 64'd1);
    b0 = bcnt;
    issue(3'd4, 32'h12345678, 32'd0, 1);
    wait_done();
    check("divu_by0", {hi_o, lo_o}, 64'h12345678_FFFFFFFF);
    check("divu_busy_cycles", 64'(bcnt - b0), 64'd33);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1);
    wait_done();
    check("div_minneg", {hi_o, lo_o}, 64'h00000000_80000000);
    issue(3'd5, 32'hAAAA, 32'd0, 1);
    issue(3'd6, 32'h5555, 32'd0, 1);
    cyc(1);
    d0 = dcnt;
    issue(3'd3, 32'd50, 32'd3, 0);
    cyc(8);
    issue(3'd1, 32'd7, 32'd9, 0);
    cancel = 1'b1;
    cyc(1);
    cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_hilo", {hi_o, lo_o}, 64'h0000AAAA_00005555);
    cyc(3);
    check("cancel_no_done", 64'(dcnt - d0), 64'd0);
    cancel = 1'b1;
    issue(3'd5, 32'h1234, 32'd0, 0);
    cancel = 1'b0;
    cyc(2);
    check("cancel_idle", {hi_o, lo_o}, 64'h0000AAAA_00005555);
    issue(3'd4, 32'd100, 32'd7, 0);
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_mid_flags", {62'd0, busy, done}, 64'd0);
    cyc(2);
    check("rst_mid_no_done", 64'(dcnt - d0), 64'd0);
    issue(3'd5, 32'hDEAD, 32'd0, 1);
    issue(3'd6, 32'hBEEF, 32'd0, 1);
    check("mthi_mtlo", {hi_o, lo_o}, 64'h0000DEAD_0000BEEF);
    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 5 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      issue(ro, ra, rb, 1);
      if (ro == 3'd3 || ro == 3'd4) wait_done();
    end
    cyc(3);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised multiply/divide execution unit that owns the HI/LO register pair. It sits in the EX stage beside the ALU and is driven by the `hilo_en`/`div`/`hassign` decode.
- It extends the single-cycle HI/LO handling with generic operand width, a multi-cycle restoring divider, a pipeline stall output and a cancel path for flushes.
- Multiply and MTHI/MTLO complete in one cycle.
- Divide holds the pipeline until HI/LO are written.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each `WIDTH` bits. Must be at least 4.
- `CNT_W`, $clog2(WIDTH+1): width of the divide iteration counter.
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: issue `op` this cycle.
- `op` input 3: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NOP).
- `a` input WIDTH: rs operand (dividend, multiplicand, or MT source).
- `b` input WIDTH: rt operand (divisor or multiplier).
- `cancel` input 1: flush; aborts an in-flight divide.
- `busy` output 1: divide in progress (registered).
- `stall` output 1: `busy | (start & idle & op is DIV/DIVU)`; combinational, holds the pipeline.
- `done` output 1: one-cycle pulse in the first cycle new HI/LO are visible.
- `hi_o` output WIDTH: HI register.
- `lo_o` output WIDTH: LO register.

## Operation
- States: IDLE, RUN, FIX. `start` is sampled only in IDLE. `start` in RUN/FIX is ignored.
- MULT/MULTU (IDLE, `start`):
  - {HI,LO} <= 2·WIDTH-bit product at the accepting edge.
  - MULT is signed × signed; MULTU is unsigned.
  - `done`=1 in the following cycle. No state change; `busy` stays 0.
- MTHI/MTLO: HI<=a or LO<=a at the accepting edge, respectively. The other register is unchanged. `done` pulses the following cycle.
- DIV/DIVU entry (IDLE → RUN): latch |a|, |b| (plain a, b for DIVU), quotient sign = a[MSB]^b[MSB] and remainder sign = a[MSB] (both 0 for DIVU). Counter <= WIDTH.
- RUN: one restoring step per cycle:
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor from rem.
  - If non-negative, keep the difference and set quo[0]=1.
  - Decrement the counter.
  - Go to FIX when the counter reaches 0.
- FIX: negate quo/rem per the latched signs, write LO<=quotient and HI<=remainder, go to IDLE.
- The most-negative ÷ −1 case (signed) yields LO=most-negative and HI=0, which falls out of the two's-complement wrap. No trap.
- Divide by zero runs the full length; no exception.
  - DIVU result: LO=all-ones, HI=a.
  - DIV result: the same pattern applied to |a|, then sign-corrected.
- `cancel` in RUN or FIX: go to IDLE at the next edge; HI/LO unchanged; no `done`. `cancel` in IDLE suppresses acceptance of a simultaneous `start` (no write of any kind).
- `rst` has priority over everything:
  - State IDLE.
  - HI=LO=0.
  - `busy`=0, `done`=0.
  - The counter and internal registers are cleared.

## Timing
- Reset values: `hi_o`=0, `lo_o`=0, `busy`=0, `done`=0. `stall` follows its equation.
- Let divide be accepted at edge E0:
  - RUN occupies the WIDTH cycles after E0.
  - FIX is one cycle; HI/LO are written at edge E(WIDTH+1).
  - `busy`=1 for exactly WIDTH+1 cycles.
  - `done`=1 in the cycle after E(WIDTH+1). State is already IDLE then, so a back-to-back `start` is accepted in that cycle.
- Multiply/MT latency: 1 edge to HI/LO; `done` in the next cycle.
- `stall` is high in the issuing cycle of a divide and through all RUN/FIX cycles. It is low in the `done` cycle.

## Configuration
- `HILO_FWD_EN` defined:
  - `hi_o`/`lo_o` combinationally bypass the value being written in the same cycle (MT, MULT, or FIX write).
  - A dependent MFHI/MFLO in the following pipeline slot reads the new value without a bubble.
  - `done` timing is unchanged.
- `HILO_FWD_EN` undefined: `hi_o`/`lo_o` are pure register outputs, with new values visible one cycle after the write edge.

## Test plan
- Reset mid-divide: DIVU a=100, b=7, assert `rst` in RUN cycle 5 → next cycle HI=LO=0, `busy`=0, no `done`.
- MULT a=−3 (0xFFFFFFFD), b=5 → next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1, `done`=1, `busy` never 1. MULTU with the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- DIV a=−7, b=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). `busy` high for exactly 33 cycles, `done` pulses once, and `stall` is high in the issue cycle.
- DIVU a=0x12345678, b=0 → LO=0xFFFFFFFF, HI=0x12345678 after the full 33-cycle latency.
- `cancel` in RUN cycle 10 of DIV a=50, b=3 with prior HI=0xAAAA, LO=0x5555 → IDLE next cycle, HI/LO unchanged, no `done`. `start` while `busy` is ignored.
- MTHI a=0xDEAD then MTLO a=0xBEEF on consecutive cycles → HI=0xDEAD, LO=0xBEEF. With `HILO_FWD_EN`, `hi_o` shows 0xDEAD in the write cycle itself.
